// File: rtl/gte_pkg.sv
// Shared types, register indices and FLAG masks for the GTE result bank.
package gte_pkg;

  // Writeback target selected by the compute-path sequencer.
  typedef enum logic [3:0] {
    WB_MAC0, WB_MAC1, WB_MAC2, WB_MAC3,
    WB_IR0, WB_IR1, WB_IR2, WB_IR3,
    WB_OTZ, WB_SX_STAGE, WB_SY_PUSH, WB_PUSH_Z,
    WB_COL_R, WB_COL_G, WB_COL_B_PUSH
  } gteWbSel;

  // Every bank register, exported to the compute path and the sequencer.
  typedef struct packed {
    logic signed [31:0] mac0;
    logic signed [31:0] mac1;
    logic signed [31:0] mac2;
    logic signed [31:0] mac3;
    logic signed [15:0] ir0;
    logic signed [15:0] ir1;
    logic signed [15:0] ir2;
    logic signed [15:0] ir3;
    logic        [15:0] otz;
    logic        [31:0] sxy0;
    logic        [31:0] sxy1;
    logic        [31:0] sxy2;
    logic        [15:0] sz0;
    logic        [15:0] sz1;
    logic        [15:0] sz2;
    logic        [15:0] sz3;
    logic        [31:0] rgb0;
    logic        [31:0] rgb1;
    logic        [31:0] rgb2;
    logic        [31:0] flag;
  } gteResRegs;

  // Data-space register indices.
  localparam logic [4:0] REG_OTZ  = 5'd7;
  localparam logic [4:0] REG_IR0  = 5'd8;
  localparam logic [4:0] REG_IR1  = 5'd9;
  localparam logic [4:0] REG_IR2  = 5'd10;
  localparam logic [4:0] REG_IR3  = 5'd11;
  localparam logic [4:0] REG_SXY0 = 5'd12;
  localparam logic [4:0] REG_SXY1 = 5'd13;
  localparam logic [4:0] REG_SXY2 = 5'd14;
  localparam logic [4:0] REG_SXYP = 5'd15;
  localparam logic [4:0] REG_SZ0  = 5'd16;
  localparam logic [4:0] REG_SZ1  = 5'd17;
  localparam logic [4:0] REG_SZ2  = 5'd18;
  localparam logic [4:0] REG_SZ3  = 5'd19;
  localparam logic [4:0] REG_RGB0 = 5'd20;
  localparam logic [4:0] REG_RGB1 = 5'd21;
  localparam logic [4:0] REG_RGB2 = 5'd22;
  localparam logic [4:0] REG_MAC0 = 5'd24;
  localparam logic [4:0] REG_MAC1 = 5'd25;
  localparam logic [4:0] REG_MAC2 = 5'd26;
  localparam logic [4:0] REG_MAC3 = 5'd27;
  localparam logic [4:0] REG_IRGB = 5'd28;
  localparam logic [4:0] REG_ORGB = 5'd29;

  // Control-space register index.
  localparam logic [4:0] CREG_FLAG = 5'd31;

  // Sticky/writable FLAG bits, and the bits summarised into bit 31.
  localparam logic [31:0] FLAG_WR_MASK  = 32'h7FFF_F000;
  localparam logic [31:0] FLAG_ERR_MASK = 32'h7F87_E000;

  // FLAG as seen by the CPU and o_res: stored sticky bits plus the summary bit.
  function automatic logic [31:0] flagView(input logic [31:0] sticky);
    return {|(sticky & FLAG_ERR_MASK), sticky[30:0]};
  endfunction

endpackage

// File: rtl/gte_orgb_pack.sv
// Packs IR1-3 into the 15-bit ORGB color: each field is IRn >> 7 clamped to 0..31.
module gte_orgb_pack (
  input  logic signed [15:0] i_ir1,
  input  logic signed [15:0] i_ir2,
  input  logic signed [15:0] i_ir3,
  output logic        [14:0] o_orgb
);

  function automatic logic [4:0] sat5(input logic signed [15:0] v);
    logic signed [15:0] s;
    s = v >>> 7;
    if (s < 16'sd0)       return 5'h00;
    else if (s > 16'sd31) return 5'h1F;
    else                  return s[4:0];
  endfunction

  // Saturate and pack {B, G, R}.
  always_comb begin
    o_orgb = {sat5(i_ir3), sat5(i_ir2), sat5(i_ir1)};
  end

endmodule

// File: rtl/gte_result_bank.sv
// GTE result register bank: MAC/IR/OTZ, SXY/SZ/RGB FIFOs, sticky FLAG, COP2 CPU access.
import gte_pkg::*;

module gte_result_bank (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_instStart,
  input  logic        i_wbValid,
  input  gteWbSel     i_wbSel,
  input  logic [31:0] i_val32,
  input  logic [15:0] i_val16,
  input  logic [7:0]  i_val8,
  input  logic [31:0] i_flagBits,
  input  logic        i_cpuWr,
  input  logic        i_cpuRd,
  input  logic        i_cpuCtl,
  input  logic [4:0]  i_cpuAddr,
  input  logic [31:0] i_cpuData,
  output logic [31:0] o_cpuData,
  output gteResRegs   o_res
);

  gteResRegs   r, rNxt;
  logic [15:0] sxStage, sxStageNxt;
  logic [7:0]  stR, stRNxt, stG, stGNxt;
  logic [14:0] orgb;
  logic        cpuBlock;
  logic        cpuWrEn;
  logic [31:0] rdData;

  gte_orgb_pack uOrgb (
    .i_ir1  (r.ir1),
    .i_ir2  (r.ir2),
    .i_ir3  (r.ir3),
    .o_orgb (orgb)
  );

  // A CPU write is dropped when the same-cycle writeback targets the same register or FIFO.
  always_comb begin
    cpuBlock = 1'b0;
    if (i_wbValid && !i_cpuCtl) begin
      case (i_cpuAddr)
        REG_OTZ:  cpuBlock = (i_wbSel == WB_OTZ);
        REG_IR0:  cpuBlock = (i_wbSel == WB_IR0);
        REG_IR1:  cpuBlock = (i_wbSel == WB_IR1);
        REG_IR2:  cpuBlock = (i_wbSel == WB_IR2);
        REG_IR3:  cpuBlock = (i_wbSel == WB_IR3);
        REG_IRGB: cpuBlock = (i_wbSel inside {WB_IR1, WB_IR2, WB_IR3});
        REG_SXY0, REG_SXY1, REG_SXY2, REG_SXYP:
                  cpuBlock = (i_wbSel == WB_SY_PUSH);
        REG_SZ0, REG_SZ1, REG_SZ2, REG_SZ3:
                  cpuBlock = (i_wbSel == WB_PUSH_Z);
        REG_RGB0, REG_RGB1, REG_RGB2:
                  cpuBlock = (i_wbSel == WB_COL_B_PUSH);
        REG_MAC0: cpuBlock = (i_wbSel == WB_MAC0);
        REG_MAC1: cpuBlock = (i_wbSel == WB_MAC1);
        REG_MAC2: cpuBlock = (i_wbSel == WB_MAC2);
        REG_MAC3: cpuBlock = (i_wbSel == WB_MAC3);
        default:  cpuBlock = 1'b0;
      endcase
    end
    cpuWrEn = i_cpuWr && !cpuBlock;
  end

  // Next-state: CPU write first, then writeback; conflicts are already filtered so order is free.
  always_comb begin
    rNxt       = r;
    sxStageNxt = sxStage;
    stRNxt     = stR;
    stGNxt     = stG;

    if (cpuWrEn && !i_cpuCtl) begin
      case (i_cpuAddr)
        REG_OTZ:  rNxt.otz  = i_cpuData[15:0];
        REG_IR0:  rNxt.ir0  = i_cpuData[15:0];
        REG_IR1:  rNxt.ir1  = i_cpuData[15:0];
        REG_IR2:  rNxt.ir2  = i_cpuData[15:0];
        REG_IR3:  rNxt.ir3  = i_cpuData[15:0];
        REG_SXY0: rNxt.sxy0 = i_cpuData;
        REG_SXY1: rNxt.sxy1 = i_cpuData;
        REG_SXY2: rNxt.sxy2 = i_cpuData;
        REG_SXYP: begin
          rNxt.sxy0 = r.sxy1;
          rNxt.sxy1 = r.sxy2;
          rNxt.sxy2 = i_cpuData;
        end
        REG_SZ0:  rNxt.sz0  = i_cpuData[15:0];
        REG_SZ1:  rNxt.sz1  = i_cpuData[15:0];
        REG_SZ2:  rNxt.sz2  = i_cpuData[15:0];
        REG_SZ3:  rNxt.sz3  = i_cpuData[15:0];
        REG_RGB0: rNxt.rgb0 = i_cpuData;
        REG_RGB1: rNxt.rgb1 = i_cpuData;
        REG_RGB2: rNxt.rgb2 = i_cpuData;
        REG_MAC0: rNxt.mac0 = i_cpuData;
        REG_MAC1: rNxt.mac1 = i_cpuData;
        REG_MAC2: rNxt.mac2 = i_cpuData;
        REG_MAC3: rNxt.mac3 = i_cpuData;
        REG_IRGB: begin
          rNxt.ir1 = {4'b0, i_cpuData[4:0],   7'b0};
          rNxt.ir2 = {4'b0, i_cpuData[9:5],   7'b0};
          rNxt.ir3 = {4'b0, i_cpuData[14:10], 7'b0};
        end
        default: ;
      endcase
    end

    if (i_wbValid) begin
      case (i_wbSel)
        WB_MAC0:       rNxt.mac0  = i_val32;
        WB_MAC1:       rNxt.mac1  = i_val32;
        WB_MAC2:       rNxt.mac2  = i_val32;
        WB_MAC3:       rNxt.mac3  = i_val32;
        WB_IR0:        rNxt.ir0   = i_val16;
        WB_IR1:        rNxt.ir1   = i_val16;
        WB_IR2:        rNxt.ir2   = i_val16;
        WB_IR3:        rNxt.ir3   = i_val16;
        WB_OTZ:        rNxt.otz   = i_val16;
        WB_SX_STAGE:   sxStageNxt = i_val16;
        WB_SY_PUSH: begin
          rNxt.sxy0 = r.sxy1;
          rNxt.sxy1 = r.sxy2;
          rNxt.sxy2 = {i_val16, sxStage};
        end
        WB_PUSH_Z: begin
          rNxt.sz0 = r.sz1;
          rNxt.sz1 = r.sz2;
          rNxt.sz2 = r.sz3;
          rNxt.sz3 = i_val16;
        end
        WB_COL_R:      stRNxt = i_val8;
        WB_COL_G:      stGNxt = i_val8;
        WB_COL_B_PUSH: begin
          rNxt.rgb0 = r.rgb1;
          rNxt.rgb1 = r.rgb2;
          rNxt.rgb2 = {i_val32[31:24], i_val8, stG, stR};
        end
        default: ;
      endcase
    end

    // FLAG priority: instruction start, then writeback accumulation, then CPU load.
    if (i_instStart)
      rNxt.flag = i_wbValid ? (i_flagBits & FLAG_WR_MASK) : '0;
    else if (i_wbValid)
      rNxt.flag = r.flag | (i_flagBits & FLAG_WR_MASK);
    else if (i_cpuWr && i_cpuCtl && (i_cpuAddr == CREG_FLAG))
      rNxt.flag = i_cpuData & FLAG_WR_MASK;
  end

  // CPU read mux over the pre-write register state.
  always_comb begin
    rdData = '0;
    if (i_cpuCtl) begin
      if (i_cpuAddr == CREG_FLAG) rdData = flagView(r.flag);
    end else begin
      case (i_cpuAddr)
        REG_OTZ:  rdData = {16'b0, r.otz};
        REG_IR0:  rdData = {{16{r.ir0[15]}}, r.ir0};
        REG_IR1:  rdData = {{16{r.ir1[15]}}, r.ir1};
        REG_IR2:  rdData = {{16{r.ir2[15]}}, r.ir2};
        REG_IR3:  rdData = {{16{r.ir3[15]}}, r.ir3};
        REG_SXY0: rdData = r.sxy0;
        REG_SXY1: rdData = r.sxy1;
        REG_SXY2, REG_SXYP: rdData = r.sxy2;
        REG_SZ0:  rdData = {16'b0, r.sz0};
        REG_SZ1:  rdData = {16'b0, r.sz1};
        REG_SZ2:  rdData = {16'b0, r.sz2};
        REG_SZ3:  rdData = {16'b0, r.sz3};
        REG_RGB0: rdData = r.rgb0;
        REG_RGB1: rdData = r.rgb1;
        REG_RGB2: rdData = r.rgb2;
        REG_MAC0: rdData = r.mac0;
        REG_MAC1: rdData = r.mac1;
        REG_MAC2: rdData = r.mac2;
        REG_MAC3: rdData = r.mac3;
        REG_IRGB, REG_ORGB: rdData = {17'b0, orgb};
        default:  rdData = '0;
      endcase
    end
  end

  // Register bank, staging latches and registered read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r         <= '0;
      sxStage   <= '0;
      stR       <= '0;
      stG       <= '0;
      o_cpuData <= '0;
    end else begin
      r       <= rNxt;
      sxStage <= sxStageNxt;
      stR     <= stRNxt;
      stG     <= stGNxt;
      if (i_cpuRd) o_cpuData <= rdData;
    end
  end

  // Export the bank with the FLAG summary bit filled in.
  always_comb begin
    o_res      = r;
    o_res.flag = flagView(r.flag);
  end

endmodule

// File: doc/gte_result_bank.md
# gte_result_bank

GTE result register bank and screen-FIFO stage, directly downstream of the compute path. It consumes per-cycle writeback results (32-bit MAC value, 16-bit clamped value, 8-bit color byte, overflow flag bits) under writeback-command control. It maintains MAC0-3, IR0-3, OTZ, the SXY/SZ/RGB shift FIFOs and the sticky FLAG register, and arbitrates CPU (COP2 MTC2/MFC2/CTC2/CFC2) access to those registers. Its state is exported as one packed struct that feeds the compute path and the sequencer.

## Interface
Parameters: none.

- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_instStart  in  1  first cycle of a GTE instruction; clears FLAG
- i_wbValid  in  1  writeback command valid this cycle
- i_wbSel  in  4  target, type gteWbSel: MAC0, MAC1, MAC2, MAC3, IR0, IR1, IR2, IR3, OTZ, SX_STAGE, SY_PUSH, PUSH_Z, COL_R, COL_G, COL_B_PUSH
- i_val32  in  32  MAC value
- i_val16  in  16  clamped 16-bit value
- i_val8  in  8  saturated color byte
- i_flagBits  in  32  overflow bits from this result; ORed into FLAG when i_wbValid
- i_cpuWr  in  1  CPU write strobe
- i_cpuRd  in  1  CPU read strobe
- i_cpuCtl  in  1  0 = data space, 1 = control space
- i_cpuAddr  in  5  register index
- i_cpuData  in  32  CPU write data
- o_cpuData  out  32  registered read data
- o_res  out  gteResRegs  all bank registers

## Operation
- Data-space map:
  - 7 OTZ
  - 8-11 IR0-3
  - 12-14 SXY0-2
  - 15 SXYP
  - 16-19 SZ0-3
  - 20-22 RGB0-2
  - 24-27 MAC0-3
  - 28 IRGB
  - 29 ORGB
- Control-space map: 31 FLAG only.
- Any other index reads 0 and ignores writes.
- SXY push: SXY0 <= SXY1, SXY1 <= SXY2, SXY2 <= new. Sources:
  - SY_PUSH pushes {i_val16, sxStage}, where sxStage is latched by SX_STAGE.
  - A CPU write to SXYP pushes i_cpuData.
  - A CPU read of SXYP returns SXY2.
- SZ push (PUSH_Z): SZ0 <= SZ1, SZ1 <= SZ2, SZ2 <= SZ3, SZ3 <= i_val16.
- RGB push: COL_R and COL_G latch staging bytes. COL_B_PUSH pushes {RGBC.code, i_val8, stG, stR} into RGB2 after shifting RGB0 <= RGB1 <= RGB2. RGBC.code is taken from the input struct field i_val32[31:24], which the sequencer drives.
- MACn <= i_val32. IRn, OTZ <= i_val16.
- Reads of SZ0-3 and OTZ zero-extend to 32 bits. Reads of IR0-3 sign-extend.
- IRGB write: IR1 = {d[4:0], 7'b0}, IR2 = {d[9:5], 7'b0}, IR3 = {d[14:10], 7'b0}.
- IRGB and ORGB reads both return the ORGB value:
  - each field = IRn >> 7, saturated to 0..0x1F (values below 0 give 0);
  - packed {17'b0, B, G, R}.
- FLAG:
  - bits 30..12 are sticky: OR of i_flagBits[30:12] on each valid writeback.
  - bits 11..0 read 0.
  - bit 31 = OR of bits 30..23 and 18..13, computed combinationally on read and in o_res.
  - CPU write loads bits 30..12.
  - i_instStart clears FLAG. If i_wbValid occurs in the same cycle, the result is i_flagBits only.
- Simultaneous CPU write and writeback:
  - different targets: both apply;
  - same register or same FIFO: writeback wins and the CPU write is dropped. Both IRGB and IR1-3 count as IR targets.
- Reset clears every register, staging latch and o_cpuData to 0.

## Timing
- All writes take effect on the rising edge. o_res shows new values the next cycle.
- CPU read: o_cpuData is valid 1 cycle after i_cpuRd and holds until the next read.
  - Read-before-write: it reflects state before any same-cycle write.
  - A read of SXYP in the same cycle as a push returns the pre-push SXY2.
- No stall or backpressure: one writeback per cycle is always accepted.
- Staging latches (sxStage, stR, stG) persist across instructions until overwritten.
- Reset asserted mid-instruction aborts any partial SXY or RGB staging. No push occurs.

## Structure
- Package gte_pkg holds:
  - the gteWbSel enum;
  - the gteResRegs struct (MAC0-3 signed 32, IR0-3 signed 16, OTZ 16, SXY0-2 32, SZ0-3 16, RGB0-2 32, FLAG 32);
  - localparams for data and control register indices;
  - the FLAG masks for writable bits and for bit 31.
- Sub-module gte_orgb_pack: combinational IR1-3 to 15-bit ORGB saturation, shared by read mux and o_res.

## Test plan
- Reset, then read every mapped index -> all 0. o_cpuData = 0.
- Three PUSH_Z writebacks (0x100, 0x200, 0x300), starting with SZ3 = 0x50 -> SZ0 = 0x50, SZ1 = 0x100, SZ2 = 0x200, SZ3 = 0x300.
- SX_STAGE 0xFFF0 then SY_PUSH 0x0010 -> SXY2 = 0x0010FFF0, old SXY2 in SXY1. CPU read of SXYP returns 0x0010FFF0.
- Write IRGB 0x7FFF -> IR1-3 = 0x0F80. Then write IR2 = 0xFF00 -> ORGB read = 0x7C1F.
- i_flagBits 0x00001000 then 0x00800000 -> FLAG = 0x80801000. i_instStart alone next -> FLAG = 0. CPU write 0xFFFFFFFF -> read 0xFFFFF000.
- Same-cycle writeback IR1 = 0x1234 and CPU write IR1 = 0x5678 -> IR1 = 0x1234. A CPU write to MAC2 in that cycle still applies.
